ahb_reg_subordinate: RTL

AHB_REG_SUBORDINATE -- requirements
Module: ahb_reg_subordinate

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_regfile.sv | 30 +++
 rtl/ahb_reg_subordinate.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite shared types: transfer kinds, response codes, subordinate states.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } trans_e;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

  typedef enum logic [1:0] {
    SubIdle,
    SubWait,
    SubErr1,
    SubErr2
  } sub_state_e;

  function automatic logic isActive(input logic [1:0] t);
    return (t == TransNonseq) || (t == TransSeq);
  endfunction

endpackage

// File: rtl/ahb_regfile.sv
// Word storage: one synchronous write port, one async read port,
// cleared asynchronously on reset.
module ahb_regfile #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] wIdx,
  input  logic [DataWidth-1:0]     wData,
  input  logic [$clog2(Depth)-1:0] rIdx,
  output logic [DataWidth-1:0]     rData
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wIdx] <= wData;
    end
  end

  assign rData = mem[rIdx];

endmodule

// File: rtl/ahb_reg_subordinate.sv
// AHB-Lite register-bank subordinate with programmable wait states
// and a two-cycle ERROR response for bad transfers.
module ahb_reg_subordinate
  import ahb_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Depth     = 16,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter int unsigned WaitStates = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic [1:0]           trans,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [DataWidth-1:0] wData,
  input  logic                 readyIn,
  output logic [DataWidth-1:0] rData,
  output logic                 readyOut,
  output logic                 resp
);

  localparam int unsigned Bytes    = DataWidth / 8;
  localparam int unsigned ByteBits = $clog2(Bytes);
  localparam int unsigned IdxBits  = $clog2(Depth);
  localparam logic [AddrWidth-1:0] Span = AddrWidth'(Depth * Bytes);
  localparam logic [3:0] WaitLoad = 4'(WaitStates);
  localparam logic [2:0] FullSize = 3'(ByteBits);

  sub_state_e state, stateN;
  logic [3:0] cnt, cntN;
  logic pend, pendN;
  logic [IdxBits-1:0] idx;
  logic wr;

  logic [AddrWidth-1:0] offset;
  logic inRange, aligned, sizeOk;
  logic badXfer, accept;
  logic [DataWidth-1:0] word;

  assign offset  = addr - BaseAddr;
  assign inRange = (addr >= BaseAddr) && (offset < Span);
  assign aligned = (addr[ByteBits-1:0] == '0);
  assign sizeOk  = (size == FullSize);
  assign badXfer = !(inRange && aligned && sizeOk);

  assign readyOut = !((state == SubWait) || (state == SubErr1));
  assign resp = ((state == SubErr1) || (state == SubErr2))
              ? RespError : RespOkay;
  assign accept = sel && readyIn && readyOut && isActive(trans);

  // pend marks the completing cycle of an OKAY transfer; it is only
  // ever set alongside SubIdle, which doubles as the completion state.
  always_comb begin
    stateN = state;
    cntN   = cnt;
    pendN  = 1'b0;
    unique case (state)
      SubWait: begin
        cntN = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          stateN = SubIdle;
          cntN   = 4'd0;
          pendN  = 1'b1;
        end
      end
      SubErr1: stateN = SubErr2;
      default: begin
        stateN = SubIdle;
        cntN   = 4'd0;
        if (accept) begin
          if (badXfer) begin
            stateN = SubErr1;
          end else if (WaitStates != 0) begin
            stateN = SubWait;
            cntN   = WaitLoad;
          end else begin
            pendN = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SubIdle;
      cnt   <= 4'd0;
      pend  <= 1'b0;
    end else begin
      state <= stateN;
      cnt   <= cntN;
      pend  <= pendN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      wr  <= 1'b0;
    end else if (accept) begin
      idx <= offset[ByteBits +: IdxBits];
      wr  <= write;
    end
  end

  ahb_regfile #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) uRegs (
    .clk  (clk),
    .rst  (rst),
    .we   (pend && wr),
    .wIdx (idx),
    .wData(wData),
    .rIdx (idx),
    .rData(word)
  );

  assign rData = (pend && !wr) ? word : '0;

endmodule
